barrett_result_sink: RTL and testbench

BARRETT_RESULT_SINK -- requirements
Module: barrett_result_sink

---
 rtl/params_pkg.sv | 22 ++
 rtl/barrett_result_sink_result_fifo.sv | 53 +++++
 rtl/barrett_result_sink.sv | 129 ++++++++++++
 tb/tb_barrett_result_sink.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
//------------------------------------------------------------------------------
// Module      : params_pkg
// Description : Shared widths and the result-sink state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package params_pkg;

    localparam int DATA_LENGTH = 24;
    localparam int SINK_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } sink_state_t;

endpackage

`default_nettype wire

// File: rtl/barrett_result_sink_result_fifo.sv
//------------------------------------------------------------------------------
// Module      : result_fifo
// Description : Power-of-two FIFO with wrap-bit pointers and a zeroed head when empty.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_push;
    logic         w_pop;

    // Pointers carry one extra wrap bit, so full and empty differ only in that bit.
    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign head   = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/barrett_result_sink.sv
//------------------------------------------------------------------------------
// Module      : barrett_result_sink
// Description : Collects a fixed count of Barrett results into a FIFO for readout.
//               Optional range check enabled by BARRETT_SINK_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module barrett_result_sink
    import params_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = DATA_LENGTH
) (
    input  logic                  CLK_pci_sys_clk_p,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [SINK_CNT_W-1:0] expected_i,
    input  logic                  valid_i,
    input  logic [W-1:0]          result_i,
    input  logic [W-1:0]          q_i,
    input  logic                  rd_ready_i,
    output logic                  rd_valid_o,
    output logic [W-1:0]          rd_data_o,
    output logic [SINK_CNT_W-1:0] count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [SINK_CNT_W-1:0] err_cnt_o
);

    sink_state_t           r_state;
    sink_state_t           w_state_next;
    logic [SINK_CNT_W-1:0] r_expected;
    logic [SINK_CNT_W-1:0] r_count;
    logic [SINK_CNT_W-1:0] w_count_inc;
    logic                  r_overflow;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_start;

    // A zero-length run accepts nothing while it passes through COLLECT.
    assign w_start     = start_i && (r_state == IDLE || r_state == DONE);
    assign w_accept    = (r_state == COLLECT) && valid_i && (r_expected != '0);
    assign w_pop       = rd_valid_o && rd_ready_i;
    assign w_drop      = w_accept && full_o && !w_pop;
    assign w_count_inc = r_count + 1'b1;

    result_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (CLK_pci_sys_clk_p),
        .rst_ni    (rst_ni),
        .push      (w_accept),
        .push_data (result_i),
        .pop       (w_pop),
        .head      (rd_data_o),
        .full      (full_o),
        .empty     (empty_o)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (start_i) w_state_next = COLLECT;
            COLLECT: begin
                if (r_expected == '0)
                    w_state_next = DRAIN;
                else if (w_accept && w_count_inc == r_expected)
                    w_state_next = DRAIN;
            end
            DRAIN: if (empty_o) w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_pci_sys_clk_p) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_expected <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_expected <= expected_i;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_accept) r_count    <= w_count_inc;
                if (w_drop)   r_overflow <= 1'b1;
            end
        end
    end

`ifdef BARRETT_SINK_RANGE_CHECK_EN
    logic [SINK_CNT_W-1:0] r_err_cnt;

    // Out-of-range results are counted whether or not they reach the FIFO.
    always_ff @(posedge CLK_pci_sys_clk_p) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (w_start) begin
            r_err_cnt <= '0;
        end else if (w_accept && (result_i >= q_i) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_q;
    assign w_unused_q = ^q_i;
    assign err_cnt_o  = '0;
`endif

    assign rd_valid_o = !empty_o;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign busy_o     = (r_state == COLLECT) || (r_state == DRAIN);
    assign done_o     = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_barrett_result_sink.sv
//------------------------------------------------------------------------------
// Module      : tb_barrett_result_sink
// Description : Directed scoreboard bench for barrett_result_sink.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_barrett_result_sink;

    localparam int DEPTH = 8;
    localparam int W     = 24;
    localparam logic [W-1:0] Q = 24'h7FE001;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [15:0]   expected_i = '0;
    logic          valid_i = 1'b0;
    logic [W-1:0]  result_i = '0;
    logic [W-1:0]  q_i = Q;
    logic          rd_ready_i = 1'b0;
    logic          rd_valid_o;
    logic [W-1:0]  rd_data_o;
    logic [15:0]   count_o;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   err_cnt_o;

    int checks = 0;
    int errors = 0;

    // Bench-side reference model
    logic [W-1:0] sb[$];
    int           m_st;   // 0 idle, 1 collect, 2 drain, 3 done
    int           m_exp;
    int           m_cnt;
    bit           m_ovf;
    int           m_err;
    int           n_pops;

    always #5 clk = ~clk;

    barrett_result_sink #(.DEPTH(DEPTH), .W(W)) dut (
        .CLK_pci_sys_clk_p (clk),
        .rst_ni            (rst_ni),
        .start_i           (start_i),
        .expected_i        (expected_i),
        .valid_i           (valid_i),
        .result_i          (result_i),
        .q_i               (q_i),
        .rd_ready_i        (rd_ready_i),
        .rd_valid_o        (rd_valid_o),
        .rd_data_o         (rd_data_o),
        .count_o           (count_o),
        .full_o            (full_o),
        .empty_o           (empty_o),
        .overflow_o        (overflow_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_cnt_o         (err_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        chk("count", {16'h0, count_o}, m_cnt);
        chk("overflow", {31'h0, overflow_o}, {31'h0, m_ovf});
        chk("busy", {31'h0, busy_o}, (m_st == 1 || m_st == 2) ? 1 : 0);
        chk("done", {31'h0, done_o}, (m_st == 3) ? 1 : 0);
        chk("empty", {31'h0, empty_o}, (sb.size() == 0) ? 1 : 0);
        chk("full", {31'h0, full_o}, (sb.size() == DEPTH) ? 1 : 0);
        chk("err_cnt", {16'h0, err_cnt_o}, m_err);
    endtask

    task automatic step(input logic st, input logic [15:0] ex, input logic v,
                        input logic [W-1:0] d, input logic rdy);
        int pre;
        bit pop;
        bit acc;
        bit psh;
        logic [W-1:0] e;
        start_i    = st;
        expected_i = ex;
        valid_i    = v;
        result_i   = d;
        rd_ready_i = rdy;
        pre = sb.size();
        pop = (pre > 0) && rdy;
        chk("rd_valid", {31'h0, rd_valid_o}, (pre > 0) ? 1 : 0);
        if (pop) begin
            e = sb.pop_front();
            chk("rd_data", {8'h0, rd_data_o}, {8'h0, e});
            n_pops++;
        end
        acc = (m_st == 1) && v && (m_exp != 0);
        psh = acc && (pre < DEPTH || pop);
        case (m_st)
            0, 3: if (st) begin
                m_st = 1; m_exp = ex; m_cnt = 0; m_ovf = 0; m_err = 0;
            end
            1: begin
                if (m_exp == 0) m_st = 2;
                else if (acc) begin
                    m_cnt++;
                    if (!psh) m_ovf = 1;
                    if (m_cnt == m_exp) m_st = 2;
                end
            end
            2: if (pre == 0) m_st = 3;
            default: m_st = 0;
        endcase
`ifdef BARRETT_SINK_RANGE_CHECK_EN
        if (acc && d >= Q && m_err != 16'hFFFF) m_err++;
`endif
        if (psh) sb.push_back(d);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        valid_i = 1'b0;
        chk_status();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        rd_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        sb.delete();
        m_st = 0; m_exp = 0; m_cnt = 0; m_ovf = 0; m_err = 0;
        chk_status();
        chk("rst_rd_valid", {31'h0, rd_valid_o}, 0);
        chk("rst_rd_data", {8'h0, rd_data_o}, 0);
    endtask

    task automatic drain_to_done();
        for (int i = 0; i < 40 && !done_o; i++) step(0, 0, 0, 0, 1);
        chk("drain_done", {31'h0, done_o}, 1);
    endtask

    initial begin
        // Reset state
        do_reset();

        // Normal run
        step(1, 16'd4, 0, 0, 1);
        step(0, 0, 1, 24'h000001, 1);
        step(0, 0, 1, 24'h000002, 1);
        step(0, 0, 1, 24'h7FE000, 1);
        step(0, 0, 1, 24'h000000, 1);
        drain_to_done();
        chk("normal_count", {16'h0, count_o}, 4);
        chk("normal_ovf", {31'h0, overflow_o}, 0);

        // Backpressure with drops; a start while busy must be ignored
        step(1, 16'd10, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(i == 3, 16'd1, 1, 24'h100 + i, 0);
        chk("bp_full", {31'h0, full_o}, 1);
        chk("bp_ovf", {31'h0, overflow_o}, 1);
        chk("bp_count", {16'h0, count_o}, 10);
        n_pops = 0;
        drain_to_done();
        chk("bp_pops", n_pops, 8);

        // Full FIFO with simultaneous push and pop
        step(1, 16'd10, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 24'h200 + i, 0);
        chk("pp_full_before", {31'h0, full_o}, 1);
        step(0, 0, 1, 24'h2AA, 1);
        chk("pp_full_after", {31'h0, full_o}, 1);
        chk("pp_ovf", {31'h0, overflow_o}, 0);
        step(0, 0, 1, 24'h2BB, 1);
        drain_to_done();
        chk("pp_ovf_end", {31'h0, overflow_o}, 0);

        // Zero expected count: valid_i ignored, DONE within 3 cycles
        step(1, 16'd0, 1, 24'h333, 1);
        step(0, 0, 1, 24'h334, 1);
        step(0, 0, 1, 24'h335, 1);
        chk("zero_done", {31'h0, done_o}, 1);
        chk("zero_count", {16'h0, count_o}, 0);
        chk("zero_empty", {31'h0, empty_o}, 1);

        // Range check
        step(1, 16'd2, 0, 0, 1);
        step(0, 0, 1, 24'h7FE001, 1);
        step(0, 0, 1, 24'h7FE005, 1);
        drain_to_done();
`ifdef BARRETT_SINK_RANGE_CHECK_EN
        chk("range_err", {16'h0, err_cnt_o}, 2);
`else
        chk("range_err", {16'h0, err_cnt_o}, 0);
`endif

        // Reset mid-run discards buffered results
        step(1, 16'd5, 0, 0, 0);
        step(0, 0, 1, 24'h401, 0);
        step(0, 0, 1, 24'h402, 0);
        step(0, 0, 1, 24'h403, 0);
        chk("mid_count", {16'h0, count_o}, 3);
        do_reset();
        chk("mid_empty", {31'h0, empty_o}, 1);
        chk("mid_busy", {31'h0, busy_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
